load_cell_a2d_rdr: RTL



---
 rtl/load_cell_a2d_rdr.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/load_cell_a2d_rdr.sv
// load_cell_a2d_rdr
//   SPI master polling an ADC128S-style 8-channel 12-bit A2D. Each nxt
//   request runs one conversion on the next slot of a fixed 4-slot round
//   robin (left load, right load, steer pot, battery). A conversion is a
//   16-bit channel command followed, after a 2-clk deselect gap, by a 16-bit
//   result read. On completion one reading register updates and cnv_cmplt
//   pulses for one clk.
//
// Ports
//   clk, rst_n      system clock / async active-low reset
//   nxt             one-cycle request, honoured only while idle
//   lft_ld, rght_ld, steer_pot, batt   registered 12-bit readings
//   cnv_cmplt       one-clk pulse, coincident with the reading update
//   SS_n, SCLK, MOSI, MISO             SPI (SCLK = clk/32, idles high)
module load_cell_a2d_rdr #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

    // 23 puts SCLK high with its first fall 9 clk after SS_n drops
    localparam logic [4:0] CNT_LOAD = 5'd23;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q;
    logic [4:0]  cnt_q;
    logic [4:0]  rise_q;
    logic [15:0] shft_q;
    logic        smpl_q;
    logic        ss_n_q;
    logic        gap_q;
    logic [11:0] lft_q, rght_q, steer_q, batt_q;
    logic        cmplt_q;

    logic        start;
    logic        rise_pt, fall_pt, last_pt;
    logic [2:0]  ch;

    always_comb begin
        ch = CH_LFT;
        case (ptr_q)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
    end

    assign rise_pt = !ss_n_q && (cnt_q == 5'd15);
    assign fall_pt = !ss_n_q && (cnt_q == 5'd31);
    // After the 16th rise the would-be 17th fall ends the transaction instead
    assign last_pt = fall_pt && (rise_q == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (nxt) begin
                state_d = CMD;
                start   = 1'b1;
            end
            CMD:  if (last_pt) state_d = GAP;
            GAP:  if (gap_q) begin
                state_d = READ;
                start   = 1'b1;
            end
            READ: if (last_pt) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            rise_q  <= 5'd0;
            smpl_q  <= 1'b0;
            shft_q  <= 16'h0000;
            gap_q   <= 1'b0;
            ptr_q   <= 2'd0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            steer_q <= 12'h000;
            batt_q  <= 12'h000;
            cmplt_q <= 1'b0;
        end else begin
            if (start)        ss_n_q <= 1'b0;
            else if (last_pt) ss_n_q <= 1'b1;

            // Parked at the load value while deselected, so SCLK idles high
            if (!ss_n_q && !last_pt) cnt_q <= cnt_q + 5'd1;
            else                     cnt_q <= CNT_LOAD;

            if (start)        rise_q <= 5'd0;
            else if (rise_pt) rise_q <= rise_q + 5'd1;

            if (rise_pt) smpl_q <= MISO;

            // The first fall precedes any rise: nothing has been sampled and
            // the A2D has not yet taken the command MSB, so it is skipped.
            // The end point still shifts so the 16th sample lands in bit 0.
            if (start)
                shft_q <= {2'b00, ch, 11'h000};
            else if (fall_pt && (rise_q != 5'd0))
                shft_q <= {shft_q[14:0], smpl_q};

            gap_q <= (state_q == GAP);

            cmplt_q <= (state_q == DONE);
            if (state_q == DONE) begin
                case (ptr_q)
                    2'd0:    lft_q   <= shft_q[11:0];
                    2'd1:    rght_q  <= shft_q[11:0];
                    2'd2:    steer_q <= shft_q[11:0];
                    default: batt_q  <= shft_q[11:0];
                endcase
                ptr_q <= ptr_q + 2'd1;
            end
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = cnt_q[4];
    assign MOSI      = shft_q[15] & ~ss_n_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cmplt_q;

endmodule
